dp_vec_ser16: RTL and testbench
===============================

# dp_vec_ser16

Vector-to-element serializer for the VU datapath. It accepts a 128-bit vector of eight 16-bit lanes in one handshake and emits selected lanes one per cycle on a 16-bit valid/ready stream. Elements are emitted starting at a programmable element index, with wrap-around. It sits between vector register file read-out and the 16-bit element consumers: store path, move-to-scalar, and the debug port.

## Interface
- Parameters:
- `LANES`, default 8: number of 16-bit lanes; fixed at 8 in this design.
- `ELEM_W`, default 16: element width in bits.
- Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  serializer can accept a load.
- `load_data`  in  128  vector; lane 0 = [127:112], lane 7 = [15:0].
- `load_start`  in  3  first element index.
- `load_count`  in  4  number of elements to emit; 0 is treated as 8, and values 9–15 are clamped to 8.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  16  current element.
- `out_elem`  out  3  lane index of the current element.
- `out_last`  out  1  current element is the final one of this load.
- `busy`  out  1  serializer is in state SEND.

## Operation
- State machine with two states:
  - IDLE: `load_ready`=1, `out_valid`=0.
  - SEND: `out_valid`=1.
- Load handshake: a load occurs when `load_valid` and `load_ready` are both 1.
  - Captures `load_data` into a 128-bit holding register.
  - Sets pointer `ptr` = `load_start`.
  - Sets `remaining` = effective count (1..8).
  - Next state is SEND.
- Output handshake: an element transfers when `out_valid` and `out_ready` are both 1.
  - `ptr` increments modulo 8 (7 wraps to 0).
  - `remaining` decrements by 1.
  - When `remaining`==1 at the transfer, this is the final element and the state leaves SEND.
- In SEND, outputs are driven as follows:
  - `out_data` = lane[`ptr`] of the holding register.
  - `out_elem` = `ptr`.
  - `out_last` = (`remaining`==1).
- `load_ready` = IDLE | (SEND & `out_valid` & `out_ready` & `out_last`).
  - This allows back-to-back loads with no bubble.
  - On the final transfer with a simultaneous load, the state stays in SEND and the new vector, pointer and count are loaded.
  - Otherwise the final transfer moves the state to IDLE.
- Stall: while `out_ready`=0 in SEND, all of these hold steady: `out_data`, `out_elem`, `out_last`, the holding register, `ptr` and `remaining`.
- `load_data` is ignored unless the load handshake occurs.
- A count that wraps past lane 7 wraps to lane 0. No element is ever emitted twice for a single load, because the count is clamped to at most 8.

## Timing
- Reset is synchronous: when `reset`=1 at a clock edge, the next state is IDLE.
- Values after reset:
  - `load_ready`=1
  - `out_valid`=0, `out_last`=0, `busy`=0
  - `out_data`=16'h0000, `out_elem`=0
  - holding register = 0, `ptr`=0, `remaining`=0
- Reset takes priority over any simultaneous handshake.
- Reset in the middle of SEND abandons the remaining elements; nothing further is emitted.
- Latency: the first element appears on the cycle after the load handshake. With `out_ready` held at 1, N elements take exactly N cycles.
- Throughput: one element per cycle. Continuous loads with `out_ready`=1 produce no idle cycles.
- `out_data`, `out_elem`, `out_last` and `busy` are registered/mux outputs of state only; none depends combinationally on an input.
- `load_ready` has a combinational path from `out_ready`. This path is accepted and must be documented for timing.

## Structure
- Shared package `dp_vu_pkg` holds:
  - `VU_LANES`=8, `VU_ELEM_W`=16, `VU_VEC_W`=128;
  - the state encoding `SER_IDLE`=1'b0, `SER_SEND`=1'b1;
  - a lane-slice function (lane i = [127-16i -: 16]).
- One sub-module: `dp_lane_mux8`, a combinational 8:1 mux of 16-bit lanes selected by a 3-bit index. The top level holds the FSM, holding register, `ptr` and `remaining`.

## Test plan
- Basic: load data 0x0000_1111_2222_3333_4444_5555_6666_7777, start=0, count=8, `out_ready`=1.
  - Expect 0x0000..0x7777 on 8 consecutive cycles, `out_elem` 0..7.
  - `out_last` only on 0x7777; then IDLE.
- Wrap: same data, start=6, count=4.
  - Expect `out_elem` 6,7,0,1 with `out_data` 0x6666, 0x7777, 0x0000, 0x1111.
- Count 0 and clamp:
  - count=0 emits 8 elements.
  - count=12 emits 8 elements.
  - In both cases, start=3 gives the order 3,4,5,6,7,0,1,2.
- Backpressure: random `out_ready` with a 30% duty cycle.
  - Outputs stay stable while stalled.
  - The emitted sequence is identical to the basic case.
  - No drops and no duplicates.
- Back-to-back: the second load (start=2, count=2) is presented when the first load's last element transfers.
  - `load_ready`=1 that cycle; the next cycle emits lane 2 with no bubble.
  - `busy` stays 1 throughout.
- Reset mid-operation: assert `reset` after the 3rd element of an 8-element load.
  - Next cycle: `out_valid`=0, `out_data`=0, `load_ready`=1.
  - A fresh load then emits correctly from its own start.

Source files
------------

// File: rtl/dp_vu_pkg.sv
// Shared VU datapath definitions: vector geometry, serializer state encoding
// and small helpers for lane slicing and element-count normalisation.
package dp_vu_pkg;

  localparam int VU_LANES  = 8;
  localparam int VU_ELEM_W = 16;
  localparam int VU_VEC_W  = 128;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Lane 0 sits in the most significant 16 bits; lane i = [127-16i -: 16].
  function automatic logic [VU_ELEM_W-1:0] lane_slice(
    input logic [VU_VEC_W-1:0] vec,
    input logic [2:0]          idx
  );
    return vec[(VU_VEC_W - 1) - VU_ELEM_W * int'(idx) -: VU_ELEM_W];
  endfunction

  // A count of 0 means a full vector; anything above the lane count is clamped
  // so a single load can never emit the same lane twice.
  function automatic logic [3:0] eff_count(input logic [3:0] cnt);
    if (cnt == 4'd0 || cnt > 4'(VU_LANES)) return 4'(VU_LANES);
    return cnt;
  endfunction

endpackage

// File: rtl/dp_lane_mux8.sv
// Combinational 8:1 selector of 16-bit lanes from a 128-bit vector.
module dp_lane_mux8
  import dp_vu_pkg::*;
(
  input  logic [VU_VEC_W-1:0]  vec_i,
  input  logic [2:0]           sel_i,
  output logic [VU_ELEM_W-1:0] lane_o
);

  assign lane_o = lane_slice(vec_i, sel_i);

endmodule

// File: rtl/dp_vec_ser16.sv
// Vector-to-element serializer: takes one 128-bit vector per load handshake
// and streams the selected 16-bit lanes, one per cycle, starting at a
// programmable lane and wrapping past lane 7.
//
// Timing note: load_ready depends combinationally on out_ready so a new load
// can be taken on the same cycle the last element of the previous one leaves.
// Upstream logic driving load_valid/load_data sees out_ready -> load_ready in
// the same cycle; constrain that path accordingly. All other outputs are
// functions of registered state only.
module dp_vec_ser16
  import dp_vu_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int ELEM_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [LANES*ELEM_W-1:0]   load_data,
  input  logic [2:0]                load_start,
  input  logic [3:0]                load_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELEM_W-1:0]         out_data,
  output logic [2:0]                out_elem,
  output logic                      out_last,
  output logic                      busy
);

  ser_state_e           state_q, state_d;
  logic [VU_VEC_W-1:0]  data_q,  data_d;
  logic [2:0]           ptr_q,   ptr_d;
  logic [3:0]           rem_q,   rem_d;

  logic [VU_ELEM_W-1:0] lane_sel;
  logic                 out_fire;
  logic                 load_fire;

  dp_lane_mux8 u_lane_mux (
    .vec_i  (data_q),
    .sel_i  (ptr_q),
    .lane_o (lane_sel)
  );

  // Output decode from registered state; handshake qualifiers.
  always_comb begin
    out_valid  = (state_q == SER_SEND);
    out_last   = out_valid && (rem_q == 4'd1);
    out_data   = out_valid ? lane_sel : '0;
    out_elem   = ptr_q;
    busy       = out_valid;
    out_fire   = out_valid && out_ready;
    load_ready = !out_valid || (out_fire && out_last);
    load_fire  = load_valid && load_ready;
  end

  // Next-state: a load wins over the final transfer so back-to-back loads
  // keep the serializer in SEND without a bubble.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    if (load_fire) begin
      state_d = SER_SEND;
      data_d  = load_data;
      ptr_d   = load_start;
      rem_d   = eff_count(load_count);
    end else if (out_fire) begin
      ptr_d = ptr_q + 3'd1;
      rem_d = rem_q - 4'd1;
      if (out_last) state_d = SER_IDLE;
    end
  end

  // State registers with synchronous reset taking priority over handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding register is cleared too, so out_data reads zero
      // after reset and no stale vector survives into the next load.
      state_q <= SER_IDLE;
      data_q  <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_dp_vec_ser16.sv
// Directed bench for dp_vec_ser16: basic, wrap, count normalisation,
// backpressure, back-to-back loads and reset during SEND.
module tb_dp_vec_ser16;

  localparam logic [127:0] VEC  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] load_data;
  logic [2:0]   load_start;
  logic [3:0]   load_count;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [2:0]   out_elem;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  dp_vec_ser16 dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_start (load_start),
    .load_count (load_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_elem   (out_elem),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane e of VEC holds 16'h1111 * e.
  function automatic logic [15:0] lane_of(input logic [2:0] e);
    return 16'h1111 * 16'(e);
  endfunction

  task automatic do_load(input string tag, input logic [2:0] start,
                         input logic [3:0] count);
    load_valid = 1'b1;
    load_data  = VEC;
    load_start = start;
    load_count = count;
    #1;
    check({tag, ".load_ready"}, 128'(load_ready), 128'(1'b1));
    tick();
    load_valid = 1'b0;
    load_data  = JUNK;
    load_start = 3'd0;
    load_count = 4'd0;
  endtask

  // Consume n elements starting at lane 'start' with out_ready high 'duty'
  // percent of the time; checks each presented element and stall stability.
  task automatic stream(input string tag, input logic [2:0] start,
                        input int n, input int duty);
    int          got = 0;
    int          cycles = 0;
    logic        stalled = 1'b0;
    logic [15:0] prev_data = '0;
    logic [2:0]  prev_elem = '0;
    logic        prev_last = 1'b0;
    logic [2:0]  e;
    while (got < n && cycles < 2000) begin
      out_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      #1;
      e = start + 3'(got);
      check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
      check({tag, ".busy"},  128'(busy),      128'(1'b1));
      check({tag, ".data"},  128'(out_data),  128'(lane_of(e)));
      check({tag, ".elem"},  128'(out_elem),  128'(e));
      check({tag, ".last"},  128'(out_last),  128'(got == n - 1));
      check({tag, ".load_ready"}, 128'(load_ready),
            128'(out_ready && (got == n - 1)));
      if (stalled) begin
        check({tag, ".stall_data"}, 128'(out_data), 128'(prev_data));
        check({tag, ".stall_elem"}, 128'(out_elem), 128'(prev_elem));
        check({tag, ".stall_last"}, 128'(out_last), 128'(prev_last));
      end
      prev_data = out_data;
      prev_elem = out_elem;
      prev_last = out_last;
      stalled   = !out_ready;
      if (out_ready) got++;
      cycles++;
      tick();
    end
    check({tag, ".count"}, 128'(got), 128'(n));
    if (duty >= 100) check({tag, ".cycles"}, 128'(cycles), 128'(n));
    out_ready = 1'b0;
    #1;
    check({tag, ".idle_valid"}, 128'(out_valid),  128'(1'b0));
    check({tag, ".idle_busy"},  128'(busy),       128'(1'b0));
    check({tag, ".idle_ready"}, 128'(load_ready), 128'(1'b1));
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_start = '0;
    load_count = '0;
    out_ready  = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst.load_ready", 128'(load_ready), 128'(1'b1));
    check("rst.out_valid",  128'(out_valid),  128'(1'b0));
    check("rst.out_last",   128'(out_last),   128'(1'b0));
    check("rst.busy",       128'(busy),       128'(1'b0));
    check("rst.out_data",   128'(out_data),   128'(16'h0000));
    check("rst.out_elem",   128'(out_elem),   128'(3'd0));
    reset = 1'b0;
    tick();

    // Basic: all eight lanes in order.
    do_load("basic", 3'd0, 4'd8);
    stream("basic", 3'd0, 8, 100);

    // Wrap: 6,7,0,1.
    do_load("wrap", 3'd6, 4'd4);
    stream("wrap", 3'd6, 4, 100);

    // Count 0 means 8; count 12 clamps to 8.
    do_load("cnt0", 3'd3, 4'd0);
    stream("cnt0", 3'd3, 8, 100);
    do_load("cnt12", 3'd3, 4'd12);
    stream("cnt12", 3'd3, 8, 100);

    // Backpressure at ~30% ready.
    do_load("bp", 3'd0, 4'd8);
    stream("bp", 3'd0, 8, 30);

    // Back-to-back: 5,6,7 then immediately 2,3.
    do_load("b2b1", 3'd5, 4'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("b2b1.elem", 128'(out_elem), 128'(3'd5 + 3'(k)));
      check("b2b1.last", 128'(out_last), 128'(1'b0));
      tick();
    end
    load_valid = 1'b1;
    load_data  = VEC;
    load_start = 3'd2;
    load_count = 4'd2;
    #1;
    check("b2b1.final_elem", 128'(out_elem),   128'(3'd7));
    check("b2b1.final_last", 128'(out_last),   128'(1'b1));
    check("b2b.load_ready",  128'(load_ready), 128'(1'b1));
    check("b2b.busy0",       128'(busy),       128'(1'b1));
    tick();
    load_valid = 1'b0;
    load_data  = JUNK;
    stream("b2b2", 3'd2, 2, 100);

    // Reset after the third element of an 8-element load.
    do_load("rmid", 3'd0, 4'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rmid.data", 128'(out_data), 128'(lane_of(3'(k))));
      tick();
    end
    reset = 1'b1;
    tick();
    check("rmid.out_valid",  128'(out_valid),  128'(1'b0));
    check("rmid.out_data",   128'(out_data),   128'(16'h0000));
    check("rmid.load_ready", 128'(load_ready), 128'(1'b1));
    check("rmid.busy",       128'(busy),       128'(1'b0));
    reset = 1'b0;
    tick();
    check("rmid.still_idle", 128'(out_valid),  128'(1'b0));
    out_ready = 1'b0;
    do_load("fresh", 3'd4, 4'd3);
    stream("fresh", 3'd4, 3, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
